// File: rtl/hf_reader_seq.sv
// ISO14443-A reader transaction sequencer: TX slots, guard, listen with timeout, then RX slot packing.
// Optional HF_SEQ_PARITY_EN: RX groups of 9 slots (8 data + odd parity) reported on rx_par_err.
module hf_reader_seq #(
   parameter int GUARD_SLOTS    = 8,
   parameter int TIMEOUT_SLOTS  = 1024,
   parameter int EOF_IDLE_SLOTS = 2,
   parameter int RX_MAX_SLOTS   = 2048
) (
   input  logic        osc_clk,
   input  logic        rst,
   input  logic        bit_strobe,
   input  logic        start,
   input  logic        abort,
   input  logic [8:0]  tx_len,
   input  logic        tx_bit,
   output logic        tx_bit_req,
   input  logic        curbit,
   output logic [2:0]  mod_type,
   output logic        mod_sig,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic        rx_last,
   output logic [11:0] rx_nslots,
   output logic        busy,
   output logic        done,
`ifdef HF_SEQ_PARITY_EN
   output logic        rx_par_err,
`endif
   output logic [1:0]  status
);

`ifdef HF_SEQ_PARITY_EN
   localparam int GRP = 9;
`else
   localparam int GRP = 8;
`endif
   localparam int TO_W = $clog2(TIMEOUT_SLOTS + 1);
   localparam int GD_W = $clog2(GUARD_SLOTS + 2);
   localparam int ID_W = $clog2(EOF_IDLE_SLOTS + 2);

   localparam logic [2:0] READER_MOD    = 3'b100;
   localparam logic [2:0] READER_LISTEN = 3'b011;
   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_TO  = 2'b01;
   localparam logic [1:0] ST_OVF = 2'b10;
   localparam logic [1:0] ST_ABT = 2'b11;

   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_SLOTS - 1);
   localparam logic [GD_W-1:0] GD_LAST  = GD_W'((GUARD_SLOTS > 0) ? GUARD_SLOTS - 1 : 0);
   localparam logic [ID_W-1:0] EOF_N    = ID_W'(EOF_IDLE_SLOTS);
   localparam logic [11:0]     RX_MAX   = 12'(RX_MAX_SLOTS);
   localparam logic [3:0]      GRP_LAST = 4'(GRP - 1);

   typedef enum logic [2:0] {S_IDLE, S_TX, S_GUARD, S_WAIT, S_RX, S_DONE} state_t;

   state_t          state_q;
   logic [8:0]      tx_len_q, slot_q;
   logic [GD_W-1:0] grd_q;
   logic [TO_W-1:0] to_q;
   logic [ID_W-1:0] idle_q, idle_d;
   logic [3:0]      bit_q;
   logic [GRP-1:0]  acc_q, acc_d;
   logic [11:0]     rx_nslots_q, nslots_d;
   logic [2:0]      mod_type_q;
   logic [7:0]      rx_byte_q;
   logic [1:0]      status_q;
   logic            mod_sig_q, tx_bit_req_q, rx_valid_q, rx_last_q, busy_q, done_q;
   logic            eof, ovf, grp_full;
`ifdef HF_SEQ_PARITY_EN
   logic            par_err_q;
   assign rx_par_err = par_err_q;
`endif

   assign mod_type   = mod_type_q;
   assign mod_sig    = mod_sig_q;
   assign tx_bit_req = tx_bit_req_q;
   assign rx_byte    = rx_byte_q;
   assign rx_valid   = rx_valid_q;
   assign rx_last    = rx_last_q;
   assign rx_nslots  = rx_nslots_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign status     = status_q;

   // Slot landing view of the RX accumulator, idle run and stored count.
   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < GRP; i++)
         if (bit_q == 4'(i)) acc_d[i] = curbit;
      idle_d   = curbit ? '0 : ((idle_q == EOF_N) ? idle_q : idle_q + 1'b1);
      nslots_d = (rx_nslots_q == RX_MAX) ? rx_nslots_q : rx_nslots_q + 12'd1;
      eof      = (idle_d == EOF_N);
      ovf      = (nslots_d == RX_MAX);
      grp_full = (bit_q == GRP_LAST);
   end

   always_ff @(negedge osc_clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tx_len_q     <= '0;
         slot_q       <= '0;
         grd_q        <= '0;
         to_q         <= '0;
         idle_q       <= '0;
         bit_q        <= '0;
         acc_q        <= '0;
         mod_type_q   <= READER_LISTEN;
         mod_sig_q    <= 1'b0;
         tx_bit_req_q <= 1'b0;
         rx_byte_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_last_q    <= 1'b0;
         rx_nslots_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         status_q     <= ST_OK;
`ifdef HF_SEQ_PARITY_EN
         par_err_q    <= 1'b0;
`endif
      end else begin
         tx_bit_req_q <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_last_q    <= 1'b0;
         done_q       <= 1'b0;
         if (state_q == S_IDLE) begin
            if (start && !abort) begin
               status_q    <= ST_OK;
               rx_nslots_q <= '0;
               slot_q      <= '0;
               grd_q       <= '0;
               to_q        <= '0;
               idle_q      <= '0;
               bit_q       <= '0;
               acc_q       <= '0;
               tx_len_q    <= tx_len;
               busy_q      <= 1'b1;
               if (tx_len != 9'd0) begin
                  state_q    <= S_TX;
                  mod_type_q <= READER_MOD;
               end else begin
                  state_q <= S_GUARD;
               end
            end
         end else if (state_q == S_DONE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else if (abort) begin
            // Abort drops any partial RX group and shuts the modulator off immediately.
            state_q    <= S_DONE;
            mod_type_q <= READER_LISTEN;
            mod_sig_q  <= 1'b0;
            status_q   <= ST_ABT;
            done_q     <= 1'b1;
            acc_q      <= '0;
            bit_q      <= '0;
         end else begin
            case (state_q)
               S_TX: if (bit_strobe) begin
                  if (slot_q != tx_len_q) begin
                     mod_sig_q    <= tx_bit;
                     tx_bit_req_q <= 1'b1;
                     slot_q       <= slot_q + 9'd1;
                  end else begin
                     mod_sig_q  <= 1'b0;
                     mod_type_q <= READER_LISTEN;
                     state_q    <= (GUARD_SLOTS == 0) ? S_WAIT : S_GUARD;
                  end
               end
               S_GUARD: begin
                  if (GUARD_SLOTS == 0) state_q <= S_WAIT;
                  else if (bit_strobe) begin
                     if (grd_q == GD_LAST) state_q <= S_WAIT;
                     else grd_q <= grd_q + 1'b1;
                  end
               end
               S_WAIT: if (bit_strobe) begin
                  if (curbit) state_q <= S_RX;
                  else begin
                     to_q <= to_q + 1'b1;
                     if (to_q == TO_LAST) begin
                        state_q  <= S_DONE;
                        status_q <= ST_TO;
                        done_q   <= 1'b1;
                     end
                  end
               end
               S_RX: if (bit_strobe) begin
                  rx_nslots_q <= nslots_d;
                  idle_q      <= idle_d;
                  if (grp_full) begin
                     rx_byte_q  <= acc_d[7:0];
                     rx_valid_q <= 1'b1;
                     rx_last_q  <= eof || ovf;
                     acc_q      <= '0;
                     bit_q      <= '0;
`ifdef HF_SEQ_PARITY_EN
                     par_err_q  <= ~(^acc_d);
`endif
                  end else begin
                     acc_q <= acc_d;
                     bit_q <= bit_q + 4'd1;
                     if (eof || ovf) begin
                        rx_byte_q  <= acc_d[7:0];
                        rx_valid_q <= 1'b1;
                        rx_last_q  <= 1'b1;
`ifdef HF_SEQ_PARITY_EN
                        par_err_q  <= 1'b1;
`endif
                     end
                  end
                  if (eof || ovf) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     status_q <= eof ? ST_OK : ST_OVF;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hf_reader_seq.sv
// Bench for hf_reader_seq: vector table of RX transactions plus hand sequences for TX, timeout, abort, reset.
module tb_hf_reader_seq;
   logic        osc_clk = 1'b0, rst = 1'b1, bit_strobe = 1'b0, start = 1'b0, abort = 1'b0;
   logic        tx_bit = 1'b0, curbit = 1'b0;
   logic [8:0]  tx_len = 9'd0;
   logic        tx_bit_req, mod_sig, rx_valid, rx_last, busy, done;
   logic [2:0]  mod_type;
   logic [7:0]  rx_byte;
   logic [11:0] rx_nslots;
   logic [1:0]  status;

   hf_reader_seq dut (
      .osc_clk(osc_clk), .rst(rst), .bit_strobe(bit_strobe), .start(start), .abort(abort),
      .tx_len(tx_len), .tx_bit(tx_bit), .tx_bit_req(tx_bit_req), .curbit(curbit),
      .mod_type(mod_type), .mod_sig(mod_sig), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .rx_last(rx_last), .rx_nslots(rx_nslots), .busy(busy), .done(done), .status(status)
   );

   always #5 osc_clk = ~osc_clk;

   int         n_chk = 0, n_fail = 0, done_cnt = 0, req_cnt = 0;
   logic [1:0] done_status = 2'b00;
   logic [8:0] exp_q[$];
   logic [8:0] e_mon;

   typedef struct {
      logic [8:0]  len;
      logic        gcb;
      logic [63:0] bits;
      int          nsl;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every rx_valid must match the next expected {rx_last, rx_byte}.
   always @(posedge osc_clk) begin
      if (tx_bit_req === 1'b1) req_cnt++;
      if (done === 1'b1) begin
         done_cnt++;
         done_status = status;
      end
      if (rx_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_unexpected: got %0h expected no rx_valid", {rx_last, rx_byte});
         end else begin
            e_mon = exp_q.pop_front();
            check("rx_byte", {23'd0, rx_last, rx_byte}, {23'd0, e_mon});
         end
      end
   end

   task automatic tick();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic slot(input logic tb, input logic cb);
      repeat (3) @(posedge osc_clk);
      tx_bit = tb;
      curbit = cb;
      bit_strobe = 1'b1;
      @(posedge osc_clk);
      bit_strobe = 1'b0;
      #1;
   endtask

   task automatic do_start(input logic [8:0] len, input logic ab);
      @(posedge osc_clk);
      start = 1'b1;
      abort = ab;
      tx_len = len;
      @(posedge osc_clk);
      start = 1'b0;
      abort = 1'b0;
      #1;
   endtask

   task automatic to_rx(input logic [8:0] len, input logic gcb);
      do_start(len, 1'b0);
      for (int i = 0; i < int'(len); i++) slot(i[0], 1'b0);
      if (len != 9'd0) slot(1'b0, 1'b0);
      repeat (8) slot(1'b0, gcb);
      slot(1'b0, 1'b1);
   endtask

   // Model of RX packing; queues expected bytes, then drives the slots.
   task automatic rx_run(input logic [63:0] bits, input logic alt);
      logic [7:0] acc;
      int         k, idle, cnt;
      logic       b, fin;
      acc = 8'd0; k = 0; idle = 0; cnt = 0; fin = 1'b0;
      while (!fin) begin
         b = alt ? ~cnt[0] : bits[cnt];
         acc[k] = b;
         k++;
         cnt++;
         idle = b ? 0 : idle + 1;
         fin = (idle == 2) || (cnt == 2048);
         if (k == 8) begin
            exp_q.push_back({fin, acc});
            acc = 8'd0;
            k = 0;
         end else if (fin) begin
            exp_q.push_back({1'b1, acc});
         end
      end
      for (int i = 0; i < cnt; i++) slot(1'b0, alt ? ~i[0] : bits[i]);
   endtask

   initial begin
      int d0, r0;
      vecs[0] = '{9'd3, 1'b0, 64'h0B5,  10};
      vecs[1] = '{9'd1, 1'b1, 64'h6DFF, 17};
      vecs[2] = '{9'd5, 1'b0, 64'h3F,    8};
      vecs[3] = '{9'd0, 1'b1, 64'h0,     2};
      vecs[4] = '{9'd2, 1'b0, 64'h0D,    6};

      repeat (3) @(posedge osc_clk);
      #1;
      check("rst_mod_type", 32'(mod_type), 32'h3);
      check("rst_mod_sig", 32'(mod_sig), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_status", 32'(status), 32'h0);
      check("rst_nslots", 32'(rx_nslots), 32'h0);
      check("rst_rx", {22'd0, rx_valid, rx_last, rx_byte}, 32'h0);
      check("rst_req", 32'(tx_bit_req), 32'h0);
      rst = 1'b0;
      tick();

      // TX pattern 1,0,0,1 then guard and full listen timeout.
      r0 = req_cnt;
      d0 = done_cnt;
      do_start(9'd4, 1'b0);
      check("tx_mod_type_start", 32'(mod_type), 32'h4);
      check("tx_mod_sig_start", 32'(mod_sig), 32'h0);
      check("tx_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 4; i++) begin
         logic tb;
         tb = (i == 0) || (i == 3);
         slot(tb, 1'b0);
         check("tx_mod_sig", 32'(mod_sig), 32'(tb));
         check("tx_mod_type", 32'(mod_type), 32'h4);
      end
      slot(1'b0, 1'b0);
      check("tx_end_mod_type", 32'(mod_type), 32'h3);
      check("tx_end_mod_sig", 32'(mod_sig), 32'h0);
      check("tx_req_count", 32'(req_cnt - r0), 32'd4);
      repeat (8) slot(1'b0, 1'b1);
      repeat (1023) slot(1'b0, 1'b0);
      check("to_not_early", 32'(done_cnt - d0), 32'd0);
      check("to_busy", 32'(busy), 32'h1);
      slot(1'b0, 1'b0);
      check("to_done", 32'(done_cnt - d0), 32'd1);
      check("to_status", 32'(done_status), 32'h1);
      tick();
      check("to_idle", 32'(busy), 32'h0);
      check("to_nslots", 32'(rx_nslots), 32'h0);
      check("to_status_held", 32'(status), 32'h1);

      // Table-driven RX transactions.
      for (int v = 0; v < 5; v++) begin
         to_rx(vecs[v].len, vecs[v].gcb);
         d0 = done_cnt;
         rx_run(vecs[v].bits, 1'b0);
         check("vec_done", 32'(done_cnt - d0), 32'd1);
         check("vec_status", 32'(done_status), 32'h0);
         check("vec_nslots", 32'(rx_nslots), 32'(vecs[v].nsl));
         check("vec_drained", 32'(exp_q.size()), 32'd0);
         tick();
         check("vec_idle", 32'(busy), 32'h0);
         check("vec_nslots_held", 32'(rx_nslots), 32'(vecs[v].nsl));
      end

      // Overflow: alternating slots never form an EOF.
      to_rx(9'd1, 1'b0);
      d0 = done_cnt;
      rx_run(64'h0, 1'b1);
      check("ovf_done", 32'(done_cnt - d0), 32'd1);
      check("ovf_status", 32'(done_status), 32'h2);
      check("ovf_nslots", 32'(rx_nslots), 32'd2048);
      check("ovf_drained", 32'(exp_q.size()), 32'd0);
      tick();

      // Abort in RX after 3 slots, with a strobe in the same cycle.
      to_rx(9'd1, 1'b0);
      repeat (3) slot(1'b0, 1'b1);
      d0 = done_cnt;
      repeat (2) @(posedge osc_clk);
      abort = 1'b1;
      bit_strobe = 1'b1;
      curbit = 1'b1;
      @(posedge osc_clk);
      abort = 1'b0;
      bit_strobe = 1'b0;
      #1;
      check("abt_done", 32'(done_cnt - d0), 32'd1);
      check("abt_status", 32'(done_status), 32'h3);
      check("abt_mod_type", 32'(mod_type), 32'h3);
      check("abt_nslots", 32'(rx_nslots), 32'd3);
      tick();
      check("abt_idle", 32'(busy), 32'h0);

      // start and abort together in IDLE.
      d0 = done_cnt;
      do_start(9'd5, 1'b1);
      check("sa_busy", 32'(busy), 32'h0);
      check("sa_mod_type", 32'(mod_type), 32'h3);
      tick();
      check("sa_no_done", 32'(done_cnt - d0), 32'd0);

      // start while in TX is ignored; TX length stays 2.
      r0 = req_cnt;
      do_start(9'd2, 1'b0);
      slot(1'b1, 1'b0);
      do_start(9'd5, 1'b0);
      slot(1'b1, 1'b0);
      slot(1'b1, 1'b0);
      check("re_start_mod_type", 32'(mod_type), 32'h3);
      check("re_start_req", 32'(req_cnt - r0), 32'd2);
      d0 = done_cnt;
      @(posedge osc_clk);
      abort = 1'b1;
      @(posedge osc_clk);
      abort = 1'b0;
      #1;
      check("re_start_abort_done", 32'(done_cnt - d0), 32'd1);
      tick();

      // Reset in the middle of TX.
      do_start(9'd3, 1'b0);
      slot(1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("mrst_busy", 32'(busy), 32'h0);
      check("mrst_mod_type", 32'(mod_type), 32'h3);
      check("mrst_mod_sig", 32'(mod_sig), 32'h0);
      @(posedge osc_clk);
      rst = 1'b0;
      tick();
      check("end_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
